// File: rtl/fifo_wr_arb_pkg.sv
// Shared types and constants for the packet-granular FIFO write-port arbiter.
package fifo_wr_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } arb_state_e;

    localparam logic [7:0] HDR_MARK = 8'h80;
    localparam int         MAX_REQ  = 16;
    localparam int         GRANT_W  = 4;

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// Combinational round-robin picker: first set request scanning rr_ptr+1,
// rr_ptr+2, ... modulo NUM_REQ.
module rr_pick
    import fifo_wr_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GRANT_W-1:0] rr_ptr,
    output logic [GRANT_W-1:0] idx,
    output logic               found
);

    localparam int SW = GRANT_W + 1;

    logic [SW-1:0] cand;
    logic          hit;

    // rr_ptr < NUM_REQ and k <= NUM_REQ, so one conditional subtract wraps.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        hit   = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + SW'(k);
            if (cand >= SW'(NUM_REQ)) begin
                cand = cand - SW'(NUM_REQ);
            end
            hit = 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (cand == SW'(i)) begin
                    hit = req[i];
                end
            end
            if (!found && hit) begin
                idx   = cand[GRANT_W-1:0];
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arb.sv
// Packet-granular round-robin arbiter for the async FIFO byte write port.
// Optional stall watchdog enabled by defining FIFO_WR_ARB_WDT_EN.
module fifo_wr_arb
    import fifo_wr_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int WDT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           fifo_wr_data,
    output logic                 fifo_wr_en,
    input  logic                 fifo_full,
    output logic [GRANT_W-1:0]   grant_id,
    output logic                 busy,
    output logic                 wdt_err
);

    arb_state_e         state, state_next;
    logic [GRANT_W-1:0] grant_next;
    logic [GRANT_W-1:0] rr_ptr, rr_next;
    logic [GRANT_W-1:0] pick_idx;
    logic               pick_found;
    logic               sel_valid, sel_last;
    logic [7:0]         sel_data;
    logic               wdt_fire;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req    (req_valid),
        .rr_ptr (rr_ptr),
        .idx    (pick_idx),
        .found  (pick_found)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            grant_id <= '0;
            rr_ptr   <= GRANT_W'(NUM_REQ - 1);
        end else begin
            state    <= state_next;
            grant_id <= grant_next;
            rr_ptr   <= rr_next;
        end
    end

    // Owner's request lines, muxed by grant_id.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == GRANT_W'(i)) begin
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
                sel_data  = req_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_next   = state;
        grant_next   = grant_id;
        rr_next      = rr_ptr;
        req_ready    = '0;
        fifo_wr_en   = 1'b0;
        fifo_wr_data = '0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_next = HDR;
                    grant_next = pick_idx;
                end
            end
            HDR: begin
                fifo_wr_data = HDR_MARK | {{(8-GRANT_W){1'b0}}, grant_id};
                fifo_wr_en   = !fifo_full;
                if (!fifo_full) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    req_ready[i] = (grant_id == GRANT_W'(i)) && !fifo_full;
                end
                fifo_wr_en   = sel_valid && !fifo_full;
                fifo_wr_data = sel_data;
                // A watchdog abort ends the grant like a last byte would.
                if ((fifo_wr_en && sel_last) || wdt_fire) begin
                    state_next = IDLE;
                    grant_next = '0;
                    rr_next    = grant_id;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

`ifdef FIFO_WR_ARB_WDT_EN
    localparam logic [15:0] WDT_LAST = 16'(WDT_CYCLES - 1);

    logic [15:0] wdt_cnt;

    // Only owner-idle cycles count; cycles blocked by fifo_full are exempt.
    assign wdt_fire = (state == DATA) && !sel_valid && !fifo_full && (wdt_cnt == WDT_LAST);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wdt_cnt <= '0;
            wdt_err <= 1'b0;
        end else begin
            wdt_err <= wdt_fire;
            if (state != DATA || fifo_wr_en || wdt_fire) begin
                wdt_cnt <= '0;
            end else if (!sel_valid && !fifo_full) begin
                wdt_cnt <= wdt_cnt + 16'd1;
            end
        end
    end
`else
    assign wdt_fire = 1'b0;
    assign wdt_err  = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Self-checking bench for fifo_wr_arb: per-source byte queues, FIFO-side scoreboard.
module tb_fifo_wr_arb;

    localparam int N   = 4;
    localparam int MEM = 64;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [N-1:0]   req_valid;
    logic [N*8-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [7:0]     fifo_wr_data;
    logic           fifo_wr_en;
    logic           fifo_full;
    logic [3:0]     grant_id;
    logic           busy;
    logic           wdt_err;

    fifo_wr_arb #(.NUM_REQ(N), .WDT_CYCLES(4)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .fifo_wr_data (fifo_wr_data),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_full    (fifo_full),
        .grant_id     (grant_id),
        .busy         (busy),
        .wdt_err      (wdt_err)
    );

    // ---------------- clock / cycle count ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timed out");
    end

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- source model ----------------
    logic [8:0]   src_mem [N][MEM];
    int           src_head[N] = '{default: 0};
    int           src_tail[N] = '{default: 0};
    int           src_skip[N] = '{default: 0};
    logic [N-1:0] hold_off = '0;

    task automatic enq(input int s, input logic [7:0] d, input logic last);
        src_mem[s][src_tail[s]] = {last, d};
        src_tail[s] = src_tail[s] + 1;
    endtask

    // Accept decisions sampled at negedge; new bytes presented 1 after posedge.
    initial begin : driver
        logic [N-1:0] acc;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk);
            acc = req_ready & req_valid & {N{reset_n}};
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (acc[i]) src_head[i] = src_head[i] + 1;
                if (src_head[i] < src_skip[i]) src_head[i] = src_skip[i];
                if (src_head[i] < src_tail[i] && !hold_off[i]) begin
                    req_valid[i]      = 1'b1;
                    req_data[8*i +: 8] = src_mem[i][src_head[i]][7:0];
                    req_last[i]       = src_mem[i][src_head[i]][8];
                end else begin
                    req_valid[i] = 1'b0;
                    req_last[i]  = 1'b0;
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];
    int         wr_cyc[$];
    int         wr_cnt = 0;

    task automatic push_exp(input logic [7:0] b);
        exp_q.push_back(b);
    endtask

    always @(negedge clk) begin
        if (reset_n && fifo_wr_en) begin
            wr_cyc.push_back(cyc);
            wr_cnt++;
            check_eq("wr_while_full", fifo_full, 1'b0);
            check_eq("wr_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) check_eq("wr_data", fifo_wr_data, exp_q.pop_front());
        end
    end

    // ---------------- helpers ----------------
    task automatic apply_reset();
        @(posedge clk); #2;
        reset_n   = 1'b0;
        fifo_full = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_wr(input logic [7:0] d, input string tag);
        logic seen = 1'b0;
        for (int t = 0; t < 200 && !seen; t++) begin
            @(negedge clk);
            if (fifo_wr_en && fifo_wr_data == d) seen = 1'b1;
        end
        check_eq(tag, seen, 1'b1);
    endtask

    task automatic wait_drain(input string tag);
        for (int t = 0; t < 300 && exp_q.size() != 0; t++) @(negedge clk);
        repeat (4) @(negedge clk);
        check_eq(tag, exp_q.size(), 0);
    endtask

    // ---------------- scenarios ----------------
    initial begin : main
        int   c0;
        int   w0;
        int   pulses;
        logic seen;
        reset_n   = 1'b0;
        fifo_full = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_busy",    busy, 1'b0);
        check_eq("rst_grant",   grant_id, 4'd0);
        check_eq("rst_ready",   req_ready, 4'b0000);
        check_eq("rst_wr_en",   fifo_wr_en, 1'b0);
        check_eq("rst_wr_data", fifo_wr_data, 8'h00);
        check_eq("rst_wdt",     wdt_err, 1'b0);
        @(posedge clk); #2 reset_n = 1'b1;

        // Source 2: 11,22,33; header one cycle after valid, then back-to-back.
        @(negedge clk);
        wr_cyc.delete();
        enq(2, 8'h11, 1'b0); enq(2, 8'h22, 1'b0); enq(2, 8'h33, 1'b1);
        push_exp(8'h82); push_exp(8'h11); push_exp(8'h22); push_exp(8'h33);
        c0 = cyc + 1;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            if (cyc == c0 + 2) check_eq("s1_grant", grant_id, 4'd2);
            if (cyc == c0 + 4) check_eq("s1_busy_last", busy, 1'b1);
            if (cyc == c0 + 5) check_eq("s1_busy_drop", busy, 1'b0);
        end
        wait_drain("s1_drain");
        check_eq("s1_nwr",   wr_cyc.size(), 4);
        check_eq("s1_first", wr_cyc[0], c0 + 1);
        check_eq("s1_last",  wr_cyc[3], c0 + 4);

        // Sources 0,1,3 with single-byte packets: one packet each per rotation.
        apply_reset();
        wr_cyc.delete();
        enq(0, 8'h0A, 1'b1); enq(0, 8'h0A, 1'b1);
        enq(1, 8'h1B, 1'b1);
        enq(3, 8'h3C, 1'b1);
        push_exp(8'h80); push_exp(8'h0A); push_exp(8'h81); push_exp(8'h1B);
        push_exp(8'h83); push_exp(8'h3C); push_exp(8'h80); push_exp(8'h0A);
        wait_drain("s2_drain");
        check_eq("s2_nwr",      wr_cyc.size(), 8);
        check_eq("s2_hdr_data", wr_cyc[1] - wr_cyc[0], 1);
        check_eq("s2_b2b_hdr",  wr_cyc[2] - wr_cyc[1], 2);

        // FIFO full for 5 cycles in HDR and 5 cycles mid-DATA.
        apply_reset();
        w0 = wr_cnt;
        @(posedge clk); #2 fifo_full = 1'b1;
        @(negedge clk);
        enq(1, 8'hA1, 1'b0); enq(1, 8'hA2, 1'b0); enq(1, 8'hA3, 1'b0);
        enq(1, 8'hA4, 1'b0); enq(1, 8'hA5, 1'b1);
        push_exp(8'h81); push_exp(8'hA1); push_exp(8'hA2); push_exp(8'hA3);
        push_exp(8'hA4); push_exp(8'hA5);
        seen = 1'b0;
        for (int t = 0; t < 50 && !seen; t++) begin
            @(negedge clk);
            if (busy) seen = 1'b1;
        end
        check_eq("s3_hdr_reached", seen, 1'b1);
        for (int t = 0; t < 5; t++) begin
            if (t > 0) @(negedge clk);
            check_eq("s3_hdr_stall_wr", fifo_wr_en, 1'b0);
            check_eq("s3_hdr_stall_rdy", req_ready, 4'b0000);
        end
        @(posedge clk); #2 fifo_full = 1'b0;
        wait_wr(8'hA2, "s3_see_a2");
        @(posedge clk); #2 fifo_full = 1'b1;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            check_eq("s3_dat_stall_wr", fifo_wr_en, 1'b0);
            check_eq("s3_dat_stall_rdy", req_ready, 4'b0000);
            check_eq("s3_dat_busy", busy, 1'b1);
        end
        @(posedge clk); #2 fifo_full = 1'b0;
        wait_drain("s3_drain");
        check_eq("s3_nwr", wr_cnt - w0, 6);

        // Reset during source 1's DATA while source 0 is waiting.
        apply_reset();
        enq(1, 8'hB1, 1'b0); enq(1, 8'hB2, 1'b0); enq(1, 8'hB3, 1'b0);
        enq(1, 8'hB4, 1'b0); enq(1, 8'hB5, 1'b0); enq(1, 8'hB6, 1'b1);
        push_exp(8'h81); push_exp(8'hB1); push_exp(8'hB2);
        wait_wr(8'h81, "s4_see_hdr");
        enq(0, 8'hC1, 1'b1);
        wait_wr(8'hB2, "s4_see_b2");
        check_eq("s4_ready_owner", req_ready, 4'b0010);
        hold_off[1] = 1'b1;
        @(posedge clk); #2 reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("s4_rst_busy",  busy, 1'b0);
        check_eq("s4_rst_grant", grant_id, 4'd0);
        check_eq("s4_rst_ready", req_ready, 4'b0000);
        src_skip[1] = src_tail[1];
        hold_off[1] = 1'b0;
        push_exp(8'h80); push_exp(8'hC1);
        @(posedge clk); #2 reset_n = 1'b1;
        wait_drain("s4_drain");

        // Owner drops valid mid-packet with source 2 waiting.
        apply_reset();
        enq(1, 8'hD1, 1'b0); enq(1, 8'hD2, 1'b0); enq(1, 8'hD3, 1'b1);
        enq(2, 8'hE1, 1'b1);
        push_exp(8'h81); push_exp(8'hD1);
        wait_wr(8'hD1, "s5_see_d1");
        hold_off[1] = 1'b1;
`ifdef FIFO_WR_ARB_WDT_EN
        push_exp(8'h82); push_exp(8'hE1);
`endif
        pulses = 0;
        for (int j = 1; j <= 8; j++) begin
            logic exp_w;
            @(negedge clk);
            if (wdt_err) pulses++;
`ifdef FIFO_WR_ARB_WDT_EN
            exp_w = (j == 5);
`else
            exp_w = 1'b0;
`endif
            check_eq("s5_wdt_err", wdt_err, exp_w);
        end
`ifdef FIFO_WR_ARB_WDT_EN
        check_eq("s5_wdt_pulses", pulses, 1);
        src_skip[1] = src_tail[1];
        hold_off[1] = 1'b0;
        wait_drain("s5_drain");
`else
        repeat (12) begin
            @(negedge clk);
            if (wdt_err) pulses++;
        end
        check_eq("s5_no_pulses", pulses, 0);
        check_eq("s5_grant_held", grant_id, 4'd1);
        check_eq("s5_busy_held", busy, 1'b1);
        check_eq("s5_ready_held", req_ready, 4'b0010);
        src_skip[1] = src_tail[1];
        hold_off[1] = 1'b0;
        push_exp(8'h82); push_exp(8'hE1);
        apply_reset();
        wait_drain("s5_drain");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
